fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the fetch-stage program counter and chooses its next value each cycle.
//  Sources, in priority order: exception entry, ERET return, branch/jump redirect, stall hold, PC+4.
//  Latches a redirect that arrives during a stall and applies it when the stall releases.
//  Flags instruction-fetch address errors (AdEL) for the F-stage exception path.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset
//  EXC_PC    32'h0000_4180  exception/interrupt handler entry
//  PC_LO     32'h0000_3000  lowest legal fetch address
//  PC_HI     32'h0000_6ffc  highest legal fetch address
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  reset      in   1   synchronous, active-low (0 = reset)
//  stall      in   1   hazard stall from D stage: hold PC
//  req        in   1   exception/interrupt request from CP0
//  eret       in   1   ERET executing: return to epc
//  epc        in   32  return address from CP0
//  br_taken   in   1   branch/jump redirect valid this cycle
//  br_target  in   32  redirect target address
//  pc_out     out  32  current fetch PC
//  pc_valid   out  1   pc_out is a real fetch slot (0 in BOOT)
//  exc_adel   out  1   pc_out misaligned or outside [PC_LO,PC_HI]
//  state      out  2   FSM state, for debug/trace
// BEHAVIOUR
//  Reset (reset==0 at posedge): pc_out=RESET_PC, pend_valid=0, pend_target=0, state=BOOT.
//   Reset wins over every other input; reset mid-stall or mid-pending drops all latched work.
//  States: BOOT=0, RUN=1, HOLD=2, PEND=3.  pc_valid = (state != BOOT).
//  BOOT: lasts exactly one cycle; PC not advanced; next state RUN. All inputs ignored.
//  In RUN/HOLD/PEND, next PC per posedge, first match wins:
//   1. req      : PC<=EXC_PC; clear pend; ->RUN   (overrides stall)
//   2. eret     : PC<=epc; clear pend; ->RUN      (overrides stall)
//   3. stall & br_taken : PC held; pend_valid<=1, pend_target<=br_target; ->PEND
//   4. stall    : PC held; ->PEND if pend_valid, else ->HOLD
//   5. br_taken : PC<=br_target; clear pend (new redirect supersedes pending); ->RUN
//   6. pend_valid : PC<=pend_target; clear pend; ->RUN
//   7. else     : PC<=PC+32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0); ->RUN
//  A second br_taken during an ongoing stall overwrites pend_target (last wins).
//  req and eret both high: req wins; epc ignored.
//  Latency: every redirect visible on pc_out one cycle after the input edge; no bubbles
//   beyond the BOOT cycle are inserted by this block.
//  exc_adel = (pc_out[1:0]!=0) | (pc_out<PC_LO) | (pc_out>PC_HI), combinational from pc_out.
//   It is 0 out of reset (RESET_PC legal). Not gated by pc_valid.
//   The block never self-redirects on AdEL; CP0 raises req.
//  epc/br_target are used unchecked; an illegal target simply raises exc_adel next cycle.
//  All outputs registered except exc_adel; state encodes exactly per the table above.
// TESTING
//  T1 reset=0 two cycles, then 1 -> pc_out=0x3000, pc_valid=0 for 1 cycle, then 0x3000 valid, 0x3004, 0x3008.
//  T2 RUN at 0x3010, stall=1 three cycles -> pc_out stays 0x3010, state=HOLD; release -> 0x3014.
//  T3 stall=1 and br_taken=1, br_target=0x3400 in the same cycle, stall held 2 more -> PC holds, state=PEND;
//   release -> 0x3400 then 0x3404.
//  T4 state=PEND (target 0x3400), req=1 while stall=1 -> pc_out=0x4180, pend cleared; after release -> 0x4184.
//  T5 req=1 and eret=1 with epc=0x3020 -> 0x4180. Then eret alone, epc=0x3022 -> pc_out=0x3022, exc_adel=1.
//  T6 br_target=0x6ffc -> exc_adel=0; next cycle 0x7000, exc_adel=1.
//   Separately, reset=0 asserted while in PEND -> BOOT, 0x3000, pend_valid=0.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: fetch-stage PC owner choosing exception, ERET, redirect, stall hold or PC+4 each cycle.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        exc_adel,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2, PEND = 2'd3} state_t;
  state_t st;
  logic pend_valid;
  logic [31:0] pend_target;
  assign state = st;
  assign exc_adel = (pc_out[1:0] != 2'b00) | (pc_out < PC_LO) | (pc_out > PC_HI);
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= BOOT;
      pc_out <= RESET_PC;
      pc_valid <= 1'b0;
      pend_valid <= 1'b0;
      pend_target <= 32'd0;
    end else if (st == BOOT) begin
      st <= RUN;
      pc_valid <= 1'b1;
    end else if (req) begin
      pc_out <= EXC_PC;
      pend_valid <= 1'b0;
      st <= RUN;
    end else if (eret) begin
      pc_out <= epc;
      pend_valid <= 1'b0;
      st <= RUN;
    end else if (stall && br_taken) begin
      pend_valid <= 1'b1;
      pend_target <= br_target;
      st <= PEND;
    end else if (stall) begin
      st <= pend_valid ? PEND : HOLD;
    end else if (br_taken) begin
      pc_out <= br_target;
      pend_valid <= 1'b0;
      st <= RUN;
    end else if (pend_valid) begin
      pc_out <= pend_target;
      pend_valid <= 1'b0;
      st <= RUN;
    end else begin
      pc_out <= pc_out + 32'd4;
      st <= RUN;
    end
  end
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: scoreboard bench for fetch_pc_sequencer.
module tb_fetch_pc_sequencer;
  logic clk = 0, reset = 0, stall = 0, req = 0, eret = 0, br_taken = 0;
  logic [31:0] epc = 0, br_target = 0, pc_out;
  logic pc_valid, exc_adel;
  logic [1:0] state;
  typedef struct packed {logic [31:0] pc; logic [1:0] st; logic adel;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, n = 0;
  fetch_pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .pc_out(pc_out), .pc_valid(pc_valid),
    .exc_adel(exc_adel), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic s, input logic r, input logic e, input logic [31:0] ep,
                      input logic b, input logic [31:0] bt, input logic [31:0] xpc, input logic [1:0] xst,
                      input logic xa);
    exp_t x;
    reset = rn; stall = s; req = r; eret = e; epc = ep; br_taken = b; br_target = bt;
    sb.push_back('{pc: xpc, st: xst, adel: xa});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n++;
    chk($sformatf("pc#%0d", n), pc_out, x.pc);
    chk($sformatf("state#%0d", n), {30'd0, state}, {30'd0, x.st});
    chk($sformatf("valid#%0d", n), {31'd0, pc_valid}, {31'd0, x.st != 2'd0});
    chk($sformatf("adel#%0d", n), {31'd0, exc_adel}, {31'd0, x.adel});
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    // T1: reset, one BOOT cycle, then sequential fetch
    step(0,0,0,0,0,0,0, 32'h3000, 2'd0, 0);
    step(0,0,0,0,0,0,0, 32'h3000, 2'd0, 0);
    step(1,0,0,0,0,0,0, 32'h3000, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h3004, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h3008, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h300c, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h3010, 2'd1, 0);
    // T2: plain stall
    for (int i = 0; i < 3; i++) step(1,1,0,0,0,0,0, 32'h3010, 2'd2, 0);
    step(1,0,0,0,0,0,0, 32'h3014, 2'd1, 0);
    // T3: redirect during stall is latched
    step(1,1,0,0,0,1,32'h3400, 32'h3014, 2'd3, 0);
    step(1,1,0,0,0,0,0, 32'h3014, 2'd3, 0);
    step(1,1,0,0,0,0,0, 32'h3014, 2'd3, 0);
    step(1,0,0,0,0,0,0, 32'h3400, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h3404, 2'd1, 0);
    // T4: exception during PEND clears pending
    step(1,1,0,0,0,1,32'h3400, 32'h3404, 2'd3, 0);
    step(1,1,1,0,0,0,0, 32'h4180, 2'd1, 0);
    step(1,1,0,0,0,0,0, 32'h4180, 2'd2, 0);
    step(1,0,0,0,0,0,0, 32'h4184, 2'd1, 0);
    // T5: req beats eret; misaligned epc
    step(1,0,1,1,32'h3020,0,0, 32'h4180, 2'd1, 0);
    step(1,0,0,1,32'h3022,0,0, 32'h3022, 2'd1, 1);
    step(1,0,0,0,0,0,0, 32'h3026, 2'd1, 1);
    // T6: upper bound
    step(1,0,0,0,0,1,32'h6ffc, 32'h6ffc, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h7000, 2'd1, 1);
    // last pending redirect wins
    step(1,1,0,0,0,1,32'h3100, 32'h7000, 2'd3, 1);
    step(1,1,0,0,0,1,32'h3200, 32'h7000, 2'd3, 1);
    step(1,0,0,0,0,0,0, 32'h3200, 2'd1, 0);
    // new redirect supersedes pending
    step(1,1,0,0,0,1,32'h3300, 32'h3200, 2'd3, 0);
    step(1,0,0,0,0,1,32'h3500, 32'h3500, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h3504, 2'd1, 0);
    // eret overrides stall
    step(1,1,0,1,32'h3040,0,0, 32'h3040, 2'd1, 0);
    // below PC_LO, and 32-bit wrap
    step(1,0,0,0,0,1,32'h2ffc, 32'h2ffc, 2'd1, 1);
    step(1,0,0,0,0,1,32'hfffffffc, 32'hfffffffc, 2'd1, 1);
    step(1,0,0,0,0,0,0, 32'h0, 2'd1, 1);
    // reset while PEND drops pending work; BOOT ignores inputs
    step(1,1,0,0,0,1,32'h3600, 32'h0, 2'd3, 1);
    step(0,1,0,0,0,0,0, 32'h3000, 2'd0, 0);
    step(1,0,1,0,0,1,32'h3800, 32'h3000, 2'd1, 0);
    step(1,0,0,0,0,0,0, 32'h3004, 2'd1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
